// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of one shared single-port memory.
// Port 0 is instruction fetch, port 1 is load/store; round-robin on ties.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              last_grant
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [2:0] LAT_END = 3'(MEM_LAT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic       gnt_q;
  logic       we_l;
  logic       gsel;
  logic       load;
  logic       capture;

  // A lone requester wins outright; a tie goes to the port not served last.
  assign gsel = (req0 && req1) ? ~last_grant : req1;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    capture = 1'b0;
    mem_wr  = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          load    = 1'b1;
          cnt_d   = 3'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_l) begin
          mem_wr  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == LAT_END) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        ack0    = ~gnt_q;
        ack1    = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are sampled once in IDLE and never looked at again.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_q      <= 1'b0;
      we_l       <= 1'b0;
      last_grant <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      if (load) begin
        gnt_q      <= gsel;
        last_grant <= gsel;
        we_l       <= gsel ? we1 : we0;
        mem_addr   <= gsel ? addr1 : addr0;
        mem_wdata  <= gsel ? wdata1 : wdata0;
      end
      if (capture && !gnt_q) begin
        rdata0 <= mem_rdata;
      end
      if (capture && gnt_q) begin
        rdata1 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, scoreboard monitors and
// hand sequences for round-robin, long latency and mid-access reset.
module tb_mem_port_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [63:0] addr0 = '0, wdata0 = '0;
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [63:0] addr1 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_wr, busy, last_grant;
  logic [63:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic        req1_b = 1'b0, we1_b = 1'b0;
  logic [63:0] addr1_b = '0, wdata1_b = '0;
  logic        ack0_b, ack1_b, mem_wr_b, busy_b, last_grant_b;
  logic [63:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  int n_vec = 0;
  int n_err = 0;
  int lat_b = 0;

  typedef struct {
    logic        p;
    logic        we;
    logic [63:0] rd;
  } exp_t;

  typedef struct {
    logic        p;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        drop;
    int          exp_lat;
  } vec_t;

  exp_t        sb[$];
  exp_t        sb_b[$];
  logic [63:0] m_rd[2];
  logic [63:0] m_rd_b;

  always #5 CLK = ~CLK;

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    return {32'hDEADBEEF, a[31:0] + 32'h3};
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  // Slow memory: data is only valid in the third cycle of an access.
  always @(posedge CLK or posedge RST)
    if (RST) lat_b <= 0;
    else     lat_b <= busy_b ? lat_b + 1 : 0;

  assign mem_rdata_b = (lat_b == LAT_B - 1) ? mem_fn(mem_addr_b)
                                            : 64'hBAD0BAD0BAD0BAD0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT_A)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy), .last_grant(last_grant)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT_B)) dut_b (
    .CLK(CLK), .RST(RST),
    .req0(1'b0), .we0(1'b0), .addr0(64'h0), .wdata0(64'h0),
    .ack0(ack0_b), .rdata0(rdata0_b),
    .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b),
    .ack1(ack1_b), .rdata1(rdata1_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wr(mem_wr_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b), .last_grant(last_grant_b)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin : mon_a
    exp_t e;
    if (!RST) begin
      if (ack0 || ack1) begin
        chk("ack_onehot", 64'(ack0 & ack1), 64'h0);
        chk("sb_nonempty", 64'(sb.size() != 0), 64'h1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ack_port", 64'(ack1), 64'(e.p));
          if (!e.we) m_rd[ack1] = e.rd;
        end
      end
      chk("rdata0", rdata0, m_rd[0]);
      chk("rdata1", rdata1, m_rd[1]);
    end
  end

  always @(negedge CLK) begin : mon_b
    exp_t e;
    if (!RST) begin
      chk("b_ack0", 64'(ack0_b), 64'h0);
      if (ack1_b) begin
        chk("b_sb_nonempty", 64'(sb_b.size() != 0), 64'h1);
        if (sb_b.size() != 0) begin
          e = sb_b.pop_front();
          if (!e.we) m_rd_b = e.rd;
        end
      end
      chk("b_rdata0", rdata0_b, 64'h0);
      chk("b_rdata1", rdata1_b, m_rd_b);
    end
  end

  task automatic clear_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    req1_b = 1'b0; we1_b = 1'b0; addr1_b = '0; wdata1_b = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RST = 1'b1;
    clear_inputs();
    m_rd[0] = '0; m_rd[1] = '0; m_rd_b = '0;
    sb.delete(); sb_b.delete();
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
  endtask

  task automatic drive(input logic p, input logic r, input logic w,
                       input logic [63:0] a, input logic [63:0] d);
    if (!p) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   lat = 0;
    int   wrc = 0;
    logic oth = 1'b0;
    @(negedge CLK);
    drive(v.p, 1'b1, v.we, v.addr, v.wdata);
    sb.push_back('{p: v.p, we: v.we, rd: mem_fn(v.addr)});
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_wdata", mem_wdata, v.wdata);
        chk("busy_c1", 64'(busy), 64'h1);
        if (v.drop) drive(v.p, 1'b0, v.we, v.addr, v.wdata);
      end
      if (mem_wr) wrc++;
      if (v.p ? ack0 : ack1) oth = 1'b1;
      if (v.p ? ack1 : ack0) begin
        lat = k;
        chk("last_grant", 64'(last_grant), 64'(v.p));
        drive(v.p, 1'b0, v.we, v.addr, v.wdata);
      end
    end
    chk("latency", 64'(lat), 64'(v.exp_lat));
    chk("mem_wr_cycles", 64'(wrc), 64'(v.we));
    chk("other_ack", 64'(oth), 64'h0);
    repeat (2) begin
      @(negedge CLK);
      chk("busy_idle", 64'(busy), 64'h0);
    end
  endtask

  vec_t vecs[7];

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int   nack;
    int   cyc[4];
    logic prt[4];
    int   latb;

    vecs[0] = '{1'b0, 1'b0, 64'h10, 64'h0, 1'b0, 1 + LAT_A};
    vecs[1] = '{1'b1, 1'b1, 64'h40, 64'h55, 1'b0, 2};
    vecs[2] = '{1'b1, 1'b0, 64'h20, 64'h0, 1'b0, 1 + LAT_A};
    vecs[3] = '{1'b0, 1'b1, 64'h18, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 2};
    vecs[4] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 1'b0, 1 + LAT_A};
    vecs[5] = '{1'b0, 1'b0, 64'h30, 64'h1, 1'b1, 1 + LAT_A};
    vecs[6] = '{1'b1, 1'b0, 64'h1234_5678_0000_0008, 64'h77, 1'b0, 1 + LAT_A};

    do_reset();
    chk("rst_ack0", 64'(ack0), 64'h0);
    chk("rst_ack1", 64'(ack1), 64'h0);
    chk("rst_mem_wr", 64'(mem_wr), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    chk("rst_rdata0", rdata0, 64'h0);
    chk("rst_rdata1", rdata1, 64'h0);
    chk("rst_last_grant", 64'(last_grant), 64'h1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Both ports held high: grants must alternate 0,1,0,1.
    do_reset();
    @(negedge CLK);
    drive(1'b0, 1'b1, 1'b0, 64'h100, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 64'h200, 64'h0);
    for (int i = 0; i < 4; i++)
      sb.push_back('{p: i[0], we: 1'b0,
                     rd: mem_fn(i[0] ? 64'h200 : 64'h100)});
    nack = 0;
    for (int k = 1; k <= 20 && nack < 4; k++) begin
      @(negedge CLK);
      if (ack0 || ack1) begin
        cyc[nack] = k;
        prt[nack] = ack1;
        chk("rr_last_grant", 64'(last_grant), 64'(ack1));
        nack++;
        if (nack == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    chk("rr_acks", 64'(nack), 64'h4);
    for (int i = 0; i < 4 && i < nack; i++) begin
      chk("rr_cycle", 64'(cyc[i]), 64'(2 + 3 * i));
      chk("rr_port", 64'(prt[i]), 64'(i[0]));
    end
    @(negedge CLK);
    chk("rr_busy_end", 64'(busy), 64'h0);

    // Three-cycle memory on port 1.
    @(negedge CLK);
    req1_b = 1'b1; we1_b = 1'b0; addr1_b = 64'h80;
    sb_b.push_back('{p: 1'b1, we: 1'b0, rd: mem_fn(64'h80)});
    latb = 0;
    for (int k = 1; k <= 20 && latb == 0; k++) begin
      @(negedge CLK);
      if (k <= LAT_B) chk("b_mem_addr", mem_addr_b, 64'h80);
      chk("b_busy", 64'(busy_b), 64'h1);
      if (ack1_b) begin
        latb = k;
        req1_b = 1'b0;
      end
    end
    chk("b_latency", 64'(latb), 64'(1 + LAT_B));
    @(negedge CLK);
    chk("b_busy_end", 64'(busy_b), 64'h0);

    // Reset lands in the ACCESS cycle of a port 0 write.
    @(negedge CLK);
    drive(1'b0, 1'b1, 1'b1, 64'h60, 64'h99);
    @(negedge CLK);
    chk("mid_wr_pre", 64'(mem_wr), 64'h1);
    chk("mid_lg_pre", 64'(last_grant), 64'h0);
    #2 RST = 1'b1;
    clear_inputs();
    #1;
    chk("mid_wr_post", 64'(mem_wr), 64'h0);
    chk("mid_busy_post", 64'(busy), 64'h0);
    chk("mid_ack0_post", 64'(ack0), 64'h0);
    chk("mid_lg_post", 64'(last_grant), 64'h1);
    m_rd[0] = '0; m_rd[1] = '0; m_rd_b = '0;
    sb.delete(); sb_b.delete();
    @(negedge CLK);
    #2 RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("mid_idle", 64'(busy), 64'h0);
    end
    run_vec('{1'b0, 1'b0, 64'h70, 64'h0, 1'b0, 1 + LAT_A});

    repeat (2) @(negedge CLK);
    chk("sb_drained", 64'(sb.size()), 64'h0);
    chk("sb_b_drained", 64'(sb_b.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port 64-bit memory between two requesters.
- Port 0 is instruction fetch (PC side); port 1 is the load/store data path (AluOut/B side).
- Serialises accesses through a small FSM with round-robin tie-breaking and a one-cycle ack pulse per completed transaction.
- Sits between the multicycle control state machine and a unified memory instance, so the processor can use a single memory for both instructions and data.

Parameters:
- ADDR_W, 64: width of request and memory addresses.
- DATA_W, 64: width of write/read data.
- MEM_LAT, 1: number of ACCESS cycles a read address is held before mem_rdata is captured. Legal range is 1..7.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- req0  input  1  port 0 (fetch) request level.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  port 0 completion pulse.
- rdata0  output  DATA_W  port 0 read data; valid while ack0 = 1.
- req1, we1, addr1, wdata1, ack1, rdata1: same as the port 0 signals, for port 1 (data).
- mem_addr  output  ADDR_W  registered address to memory.
- mem_wdata  output  DATA_W  registered write data to memory.
- mem_wr  output  1  memory write strobe.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  high whenever the FSM is not in IDLE.
- last_grant  output  1  index of the most recently granted port.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - ack0, ack1, mem_wr, busy = 0.
  - mem_addr, mem_wdata, rdata0, rdata1 = 0.
  - last_grant = 1, so port 0 wins the first tie.
- States: IDLE, ACCESS, DONE. A 3-bit counter cnt runs inside ACCESS.
- IDLE, on the rising edge with any req high:
  - Selection: grant g = the sole requester. If both request, g = ~last_grant.
  - Latches: mem_addr <= addr_g, mem_wdata <= wdata_g, internal we_l <= we_g.
  - Updates: last_grant <= g, cnt <= 0, next state ACCESS.
  - With no req high, remains in IDLE.
- ACCESS, write (we_l = 1):
  - mem_wr = 1 for exactly this one cycle.
  - Next state DONE.
- ACCESS, read (we_l = 0):
  - mem_wr = 0; stays for MEM_LAT cycles (cnt counts 0..MEM_LAT-1).
  - On the closing edge of the last ACCESS cycle, rdata_g <= mem_rdata.
  - Next state DONE.
- DONE:
  - ack_g = 1 for exactly one cycle; the other ack stays 0.
  - Next state IDLE.
- Latency, with cycle 0 = the IDLE cycle in which the request is sampled:
  - Read: ack in cycle 1+MEM_LAT.
  - Write: ack in cycle 2.
  - Minimum back-to-back spacing is 3 cycles (write) or MEM_LAT+2 cycles (read).
- Handshake rules:
  - Requester holds req, we, addr and wdata stable until ack.
  - req still high in the cycle after ack is treated as a new request and is re-arbitrated in IDLE.
- Output holding:
  - rdata_x holds its value until the next completed read on port x. Writes do not modify rdata.
  - mem_addr and mem_wdata hold their last value outside ACCESS.
- Request dropped mid-transaction: the transaction still completes and ack is still pulsed. Inputs are never re-sampled after IDLE.
- Fairness: under continuous requests on both ports, grants strictly alternate, so no port waits more than one foreign transaction.
- Reset mid-ACCESS: mem_wr falls immediately, no ack is issued, and the pending transaction is discarded.
- busy = (state != IDLE). It is combinational from the state register.

Test Plan:
- Reset, then req0 = 1, we0 = 0, addr0 = 0x10, MEM_LAT = 1, memory returns 0xDEADBEEF00000013 → mem_addr = 0x10 in cycle 1; ack0 = 1 in cycle 2 with rdata0 = 0xDEADBEEF00000013; ack1 = 0 throughout.
- req1 = 1, we1 = 1, addr1 = 0x40, wdata1 = 0x55 → mem_wr = 1 only in cycle 1 with mem_addr = 0x40 and mem_wdata = 0x55; ack1 in cycle 2; rdata1 unchanged.
- req0 and req1 both high and held continuously from reset (reads) → grant order 0,1,0,1; acks alternate every 3 cycles; last_grant toggles after each grant.
- MEM_LAT = 3, port 1 read of 0x80 → mem_addr = 0x80 for cycles 1–3; rdata1 captured at the end of cycle 3; ack1 in cycle 4; busy high in cycles 1–4.
- Assert RST during ACCESS of a write → mem_wr = 0 immediately; no ack; state IDLE; last_grant = 1; the next req0 is served normally.
- req0 dropped during ACCESS → ack0 still pulses once; FSM returns to IDLE with no new grant.
